// File: rtl/mem_req_queue.sv
// In-order request FIFO with per-class credit metering in front of memory_controller.
// Optional issue/stall statistics are compiled in when MEM_REQ_QUEUE_STATS_EN is defined.
module mem_req_queue #(
   parameter int DEPTH           = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // Client side: a request transfers on a rising edge where req_valid and req_ready are both 1.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_address,
   input  logic [DATA_W-1:0] req_data,
   output logic [ADDR_W-1:0] wr_address,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ret_ack,
   input  logic [ADDR_W-1:0] wr_ret_address,
   output logic [ADDR_W-1:0] rd_address,
   output logic              rd_en,
   input  logic              rd_ret_ack,
   input  logic [ADDR_W-1:0] rd_ret_address,
   input  logic [DATA_W-1:0] rd_ret_data,
   output logic              resp_rd_valid,
   output logic [ADDR_W-1:0] resp_rd_address,
   output logic [DATA_W-1:0] resp_rd_data,
   output logic              resp_wr_valid,
   output logic [ADDR_W-1:0] resp_wr_address,
   output logic              idle,
   output logic              err
`ifdef MEM_REQ_QUEUE_STATS_EN
   ,
   output logic [31:0]       stat_rd_issued,
   output logic [31:0]       stat_wr_issued,
   output logic [31:0]       stat_stall
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [7:0]       MAX_OUT = 8'(MAX_OUTSTANDING);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  write_mem;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [7:0]       rd_cnt;
   logic [7:0]       wr_cnt;

   logic push;
   logic head_write;
   logic head_credit;
   logic issue;
   logic issue_rd;
   logic issue_wr;

   // Credits are judged on registered counters, so an ack only frees a slot from the next edge.
   always_comb begin
      head_write  = write_mem[rd_ptr];
      head_credit = head_write ? (wr_cnt < MAX_OUT) : (rd_cnt < MAX_OUT);
      issue       = (count != '0) && head_credit;
      issue_rd    = issue && !head_write;
      issue_wr    = issue && head_write;
      push        = req_valid && req_ready;
   end

   assign req_ready = (count < FULL);
   assign idle      = (count == '0) && (rd_cnt == 8'd0) && (wr_cnt == 8'd0);

   function automatic logic [7:0] next_cnt(input logic [7:0] cnt, input logic inc,
                                           input logic ack);
      logic [7:0] res;
      res = cnt;
      if (inc && !ack)
         res = cnt + 8'd1;
      else if (!inc && ack && (cnt != 8'd0))
         res = cnt - 8'd1;
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr]  <= req_address;
         data_mem[wr_ptr]  <= req_data;
         write_mem[wr_ptr] <= req_write;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_cnt <= 8'd0;
         wr_cnt <= 8'd0;
         err    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (issue)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, issue})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         rd_cnt <= next_cnt(rd_cnt, issue_rd, rd_ret_ack);
         wr_cnt <= next_cnt(wr_cnt, issue_wr, wr_ret_ack);
         if ((rd_ret_ack && (rd_cnt == 8'd0)) || (wr_ret_ack && (wr_cnt == 8'd0)))
            err <= 1'b1;
      end
   end

   // Address/data registers only load on issue so they hold their last value between strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_en      <= 1'b0;
         wr_en      <= 1'b0;
         rd_address <= '0;
         wr_address <= '0;
         wr_data    <= '0;
      end else begin
         rd_en <= issue_rd;
         wr_en <= issue_wr;
         if (issue_rd)
            rd_address <= addr_mem[rd_ptr];
         if (issue_wr) begin
            wr_address <= addr_mem[rd_ptr];
            wr_data    <= data_mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_rd_valid   <= 1'b0;
         resp_rd_address <= '0;
         resp_rd_data    <= '0;
         resp_wr_valid   <= 1'b0;
         resp_wr_address <= '0;
      end else begin
         resp_rd_valid   <= rd_ret_ack;
         resp_rd_address <= rd_ret_address;
         resp_rd_data    <= rd_ret_data;
         resp_wr_valid   <= wr_ret_ack;
         resp_wr_address <= wr_ret_address;
      end
   end

`ifdef MEM_REQ_QUEUE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_rd_issued <= 32'd0;
         stat_wr_issued <= 32'd0;
         stat_stall     <= 32'd0;
      end else begin
         if (issue_rd)
            stat_rd_issued <= stat_rd_issued + 32'd1;
         if (issue_wr)
            stat_wr_issued <= stat_wr_issued + 32'd1;
         if ((count != '0) && !issue)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
